// File: rtl/booth2_seq_mul.sv
// Sequential radix-4 (Booth-2) multiplier: one Booth digit per clock through a single adder.
// Define BOOTH_MUL_UNSIGNED_EN to add the tc port (tc=0 unsigned, one extra digit).
module booth2_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   in0,
    input  logic [WIDTH-1:0]   in1,
`ifdef BOOTH_MUL_UNSIGNED_EN
    input  logic               tc,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out
);
    localparam int AW = 2*WIDTH + 2;
`ifdef BOOTH_MUL_UNSIGNED_EN
    localparam int BW   = WIDTH + 2;
    localparam int NMAX = WIDTH/2 + 1;
`else
    localparam int BW   = WIDTH;
    localparam int NMAX = WIDTH/2;
`endif
    localparam int CW = $clog2(NMAX);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [AW-1:0] acc;
    logic [AW-1:0] a_sh;
    logic [BW-1:0] b_sh;
    logic          b_prev;
    logic [CW-1:0] count;
    logic [CW-1:0] last_idx;
    logic [AW-1:0] a_ext;
    logic [BW-1:0] b_ext;

`ifdef BOOTH_MUL_UNSIGNED_EN
    logic tc_q;
    assign a_ext    = {{(AW-WIDTH){tc & in0[WIDTH-1]}}, in0};
    assign b_ext    = {{2{tc & in1[WIDTH-1]}}, in1};
    assign last_idx = tc_q ? CW'(WIDTH/2 - 1) : CW'(WIDTH/2);
`else
    assign a_ext    = {{(AW-WIDTH){in0[WIDTH-1]}}, in0};
    assign b_ext    = in1;
    assign last_idx = CW'(NMAX - 1);
`endif

    // Multiplicand and multiplier shift by two each digit, so the current
    // digit always sits in b_sh[1:0] plus the previously consumed bit.
    logic [2:0]    digit;
    logic          neg;
    logic [AW-1:0] mag;
    logic [AW-1:0] addend;
    logic [AW-1:0] sum;

    always_comb begin
        digit = {b_sh[1], b_sh[0], b_prev};
        neg   = digit[2] & ~(digit[1] & digit[0]);
        mag   = '0;
        case (digit)
            3'b001, 3'b010, 3'b101, 3'b110: mag = a_sh;
            3'b011, 3'b100:                 mag = {a_sh[AW-2:0], 1'b0};
            default:                        mag = '0;
        endcase
        addend = neg ? ~mag : mag;
        sum    = acc + addend + AW'(neg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            out    <= '0;
            acc    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            b_prev <= 1'b0;
            count  <= '0;
`ifdef BOOTH_MUL_UNSIGNED_EN
            tc_q   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= a_ext;
                        b_sh   <= b_ext;
                        b_prev <= 1'b0;
                        acc    <= '0;
                        count  <= '0;
`ifdef BOOTH_MUL_UNSIGNED_EN
                        tc_q   <= tc;
`endif
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    acc    <= sum;
                    a_sh   <= a_sh << 2;
                    b_sh   <= b_sh >> 2;
                    b_prev <= b_sh[1];
                    count  <= count + CW'(1);
                    if (count == last_idx) begin
                        out   <= sum[2*WIDTH-1:0];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_booth2_seq_mul.sv
// Self-checking bench for booth2_seq_mul: directed handshake/corner tests at WIDTH=8
// plus randomised sweeps at WIDTH=4, 8 and 16 against an arithmetic reference.
module tb_booth2_seq_mul;
    int checks   = 0;
    int failures = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic [7:0]  in0 = '0, in1 = '0;
    logic        busy, done;
    logic [15:0] out;

    logic        s4_start = 1'b0;
    logic [3:0]  s4_in0 = '0, s4_in1 = '0;
    logic        s4_busy, s4_done;
    logic [7:0]  s4_out;

    logic        s16_start = 1'b0;
    logic [15:0] s16_in0 = '0, s16_in1 = '0;
    logic        s16_busy, s16_done;
    logic [31:0] s16_out;

`ifdef BOOTH_MUL_UNSIGNED_EN
    logic tc = 1'b1, s4_tc = 1'b1, s16_tc = 1'b1;
`endif

    booth2_seq_mul #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in0(in0), .in1(in1),
`ifdef BOOTH_MUL_UNSIGNED_EN
        .tc(tc),
`endif
        .busy(busy), .done(done), .out(out)
    );

    booth2_seq_mul #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4_start), .in0(s4_in0), .in1(s4_in1),
`ifdef BOOTH_MUL_UNSIGNED_EN
        .tc(s4_tc),
`endif
        .busy(s4_busy), .done(s4_done), .out(s4_out)
    );

    booth2_seq_mul #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(s16_start), .in0(s16_in0), .in1(s16_in1),
`ifdef BOOTH_MUL_UNSIGNED_EN
        .tc(s16_tc),
`endif
        .busy(s16_busy), .done(s16_done), .out(s16_out)
    );

    // Exact product from plain integer arithmetic, truncated to 2*w bits.
    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input logic sgn);
        longint sa, sb, p;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        return 32'(p & ((longint'(1) << (2*w)) - 1));
    endfunction

    function automatic logic [15:0] pick(input int w);
        logic [15:0] v, mask;
        mask = 16'((32'd1 << w) - 1);
        case ($urandom_range(0, 5))
            0:       v = mask;
            1:       v = 16'(1) << $urandom_range(0, w-1);
            2:       v = '0;
            3:       v = mask ^ (16'(1) << $urandom_range(0, w-1));
            default: v = 16'($urandom);
        endcase
        return v & mask;
    endfunction

    function automatic logic rand_tc();
`ifdef BOOTH_MUL_UNSIGNED_EN
        return 1'($urandom_range(0, 1));
`else
        return 1'b1;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one WIDTH=8 operation and wait (bounded) for done; counts busy cycles.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic t,
                        output logic [15:0] res, output int cyc);
        int n;
        in0 = a;
        in1 = b;
`ifdef BOOTH_MUL_UNSIGNED_EN
        tc = t;
`endif
        start = 1'b1;
        step();
        start = 1'b0;
        in0 = 8'($urandom);
        in1 = 8'($urandom);
        cyc = 0;
        n = 0;
        while (!done && n < 40) begin
            if (busy) cyc++;
            step();
            n++;
        end
        res = out;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL run8_timeout: done=%b after %0d cycles, required done=1", done, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b required 0", done); end
        checks++; if (out !== 16'h0) begin failures++; $display("FAIL reset_out: got %h required 0000", out); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [15:0] r;
        int c;
        run8(8'd3, 8'hFB, 1'b1, r, c);
        checks++; if (r !== 16'hFFF1) begin failures++; $display("FAIL basic_out: got %h required fff1", r); end
        checks++; if (c !== 4) begin failures++; $display("FAIL basic_busy_cycles: got %0d required 4", c); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_in_done: got %b required 0", busy); end
        step();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse: got %b required 0", done); end
        checks++; if (out !== 16'hFFF1) begin failures++; $display("FAIL basic_out_held: got %h required fff1", out); end
    endtask

    task automatic test_corner();
        logic [15:0] r;
        int c;
        run8(8'h80, 8'h80, 1'b1, r, c);
        checks++; if (r !== 16'h4000) begin failures++; $display("FAIL corner_80x80: got %h required 4000", r); end
        run8(8'h7F, 8'h80, 1'b1, r, c);
        checks++; if (r !== 16'hC080) begin failures++; $display("FAIL corner_7fx80: got %h required c080", r); end
        run8(8'h80, 8'h7F, 1'b1, r, c);
        checks++; if (r !== 16'hC080) begin failures++; $display("FAIL corner_80x7f: got %h required c080", r); end
    endtask

    task automatic test_start_ignored();
        int cyc, k;
        in0 = 8'd10;
        in1 = 8'hF9;
`ifdef BOOTH_MUL_UNSIGNED_EN
        tc = 1'b1;
`endif
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        k = 0;
        while (!done && k < 40) begin
            if (busy) cyc++;
            if (k == 1) begin start = 1'b1; in0 = 8'h55; in1 = 8'h33; end
            if (k == 2) start = 1'b0;
            step();
            k++;
        end
        checks++; if (out !== 16'hFFBA || !done) begin failures++; $display("FAIL ignored_start_out: got %h done=%b required ffba done=1", out, done); end
        checks++; if (cyc !== 4) begin failures++; $display("FAIL ignored_start_cycles: got %0d required 4", cyc); end
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignored_start_no_restart: busy=%b required 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a1, b1, a2, b2;
        logic [15:0] p1, p2, r;
        int c, k;
        bit stable;
        a1 = 8'($urandom); b1 = 8'($urandom);
        a2 = 8'($urandom); b2 = 8'($urandom);
        p1 = 16'(ref_mul(8, 16'(a1), 16'(b1), 1'b1));
        p2 = 16'(ref_mul(8, 16'(a2), 16'(b2), 1'b1));
        run8(a1, b1, 1'b1, r, c);
        checks++; if (r !== p1) begin failures++; $display("FAIL b2b_first: got %h required %h", r, p1); end
        in0 = a2;
        in1 = b2;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_rise: got %b required 1", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_fall: got %b required 0", done); end
        stable = 1'b1;
        c = 0;
        k = 0;
        while (!done && k < 40) begin
            if (busy) c++;
            if (out !== p1) stable = 1'b0;
            step();
            k++;
        end
        checks++; if (!stable) begin failures++; $display("FAIL b2b_out_stable: out changed during run, required %h", p1); end
        checks++; if (out !== p2 || !done) begin failures++; $display("FAIL b2b_second: got %h done=%b required %h done=1", out, done, p2); end
        checks++; if (c !== 4) begin failures++; $display("FAIL b2b_cycles: got %0d required 4", c); end
    endtask

`ifdef BOOTH_MUL_UNSIGNED_EN
    task automatic test_unsigned();
        logic [15:0] r;
        int c;
        run8(8'hFF, 8'hFF, 1'b0, r, c);
        checks++; if (r !== 16'hFE01) begin failures++; $display("FAIL unsigned_out: got %h required fe01", r); end
        checks++; if (c !== 5) begin failures++; $display("FAIL unsigned_cycles: got %0d required 5", c); end
        run8(8'hFF, 8'hFF, 1'b1, r, c);
        checks++; if (r !== 16'h0001) begin failures++; $display("FAIL signed_ff_out: got %h required 0001", r); end
        checks++; if (c !== 4) begin failures++; $display("FAIL signed_ff_cycles: got %0d required 4", c); end
    endtask
`endif

    task automatic test_reset_mid_run();
        logic [15:0] r;
        int c;
        bit quiet;
        run8(8'd5, 8'd7, 1'b1, r, c);
        checks++; if (r !== 16'd35) begin failures++; $display("FAIL midrst_pre: got %h required 0023", r); end
        step();
        in0 = 8'd9;
        in1 = 8'd11;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b required 0", done); end
        checks++; if (out !== 16'h0) begin failures++; $display("FAIL midrst_out: got %h required 0000", out); end
        #2;
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done || busy) quiet = 1'b0;
        end
        checks++; if (!quiet) begin failures++; $display("FAIL midrst_no_done: activity after abort, required none"); end
        run8(8'hF3, 8'd6, 1'b1, r, c);
        checks++; if (r !== 16'hFFB2) begin failures++; $display("FAIL midrst_after: got %h required ffb2", r); end
    endtask

    task automatic test_random8();
        logic [7:0]  a, b;
        logic [15:0] r, e;
        logic        t;
        int c;
        for (int i = 0; i < 1000; i++) begin
            a = 8'(pick(8));
            b = 8'(pick(8));
            t = rand_tc();
            e = 16'(ref_mul(8, 16'(a), 16'(b), t));
            run8(a, b, t, r, c);
            checks++;
            if (r !== e || c !== (t ? 4 : 5)) begin
                failures++;
                $display("FAIL rand8 a=%h b=%h tc=%b: got %h in %0d cycles required %h", a, b, t, r, c, e);
            end
        end
    endtask

    task automatic test_random4();
        logic [3:0] a, b;
        logic [7:0] e;
        logic       t;
        int k;
        for (int i = 0; i < 1000; i++) begin
            a = 4'(pick(4));
            b = 4'(pick(4));
            t = rand_tc();
            e = 8'(ref_mul(4, 16'(a), 16'(b), t));
            s4_in0 = a;
            s4_in1 = b;
`ifdef BOOTH_MUL_UNSIGNED_EN
            s4_tc = t;
`endif
            s4_start = 1'b1;
            step();
            s4_start = 1'b0;
            k = 0;
            while (!s4_done && k < 20) begin step(); k++; end
            checks++;
            if (!s4_done || s4_out !== e) begin
                failures++;
                $display("FAIL rand4 a=%h b=%h tc=%b: got %h done=%b required %h", a, b, t, s4_out, s4_done, e);
            end
        end
    endtask

    task automatic test_random16();
        logic [15:0] a, b;
        logic [31:0] e;
        logic        t;
        int k;
        for (int i = 0; i < 1000; i++) begin
            a = pick(16);
            b = pick(16);
            t = rand_tc();
            e = ref_mul(16, a, b, t);
            s16_in0 = a;
            s16_in1 = b;
`ifdef BOOTH_MUL_UNSIGNED_EN
            s16_tc = t;
`endif
            s16_start = 1'b1;
            step();
            s16_start = 1'b0;
            k = 0;
            while (!s16_done && k < 30) begin step(); k++; end
            checks++;
            if (!s16_done || s16_out !== e) begin
                failures++;
                $display("FAIL rand16 a=%h b=%h tc=%b: got %h done=%b required %h", a, b, t, s16_out, s16_done, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corner();
        test_start_ignored();
        test_back_to_back();
`ifdef BOOTH_MUL_UNSIGNED_EN
        test_unsigned();
`endif
        test_reset_mid_run();
        test_random8();
        test_random4();
        test_random16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
